rf_wr_arbiter: RTL and testbench
================================

Name: rf_wr_arbiter

Overview:
- Shares the single register-file write port (we/wAddr/wData) between two writeback requesters.
  - Requester A: ALU writeback.
  - Requester B: load/memory writeback.
- Round-robin arbitration with valid/ready handshake.
- One registered output stage drives the register file directly.
- Discards writes to register $0 and counts arbitration stalls for debug.

Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register address width
- ZERO_REG_EN, 1, 1 = writes to address 0 complete the handshake but never assert we
- CNT_W, 16, width of stall and drop counters

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-low reset
- flush  input  1  synchronous; kills the output stage this cycle
- a_valid  input  1  requester A has a write
- a_ready  output  1  requester A write accepted this cycle
- a_addr  input  ADDR_W  A destination register
- a_data  input  DATA_W  A write data
- b_valid  input  1  requester B has a write
- b_ready  output  1  requester B write accepted this cycle
- b_addr  input  ADDR_W  B destination register
- b_data  input  DATA_W  B write data
- we  output  1  register-file write enable (registered)
- wAddr  output  ADDR_W  register-file write address (registered)
- wData  output  DATA_W  register-file write data (registered)
- stall_cnt  output  CNT_W  cycles in which a valid requester was not granted, saturating
- drop_cnt  output  CNT_W  accepted writes to address 0 that were discarded, saturating

Behaviour:
- Reset (rst=0, async): we=0, wAddr=0, wData=0, stall_cnt=0, drop_cnt=0, last_grant=B (so A wins the first tie).
- Readies are combinational from the valids and last_grant. They do not depend on the addr/data inputs.
- Grant rules:
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant the requester that is not last_grant.
  - Neither valid: no grant, last_grant unchanged.
- At most one ready is high per cycle. The register file never back-pressures, so a lone valid is always granted in the same cycle.
- last_grant updates on every grant.
- Handshake: a requester holds valid, addr and data stable until it sees ready. Deasserting valid before ready is legal, and the request is simply withdrawn.
- Latency: a write accepted in cycle N appears on we/wAddr/wData in cycle N+1 and stays for exactly one cycle. Back-to-back grants give back-to-back writes.
- With no grant in cycle N, we=0 in N+1. wAddr/wData hold their previous values.
- Zero register: when ZERO_REG_EN=1 and the granted addr==0:
  - the ready still asserts;
  - we=0 next cycle;
  - drop_cnt increments.
  - When ZERO_REG_EN=0, address 0 is written like any other.
- Same-address collision: both valid to the same addr are serialized in round-robin order, and the last write wins. Program order is the requesters' responsibility.
- stall_cnt: +1 per cycle in which both valids are high (exactly one requester is stalled). It saturates at all-ones and does not wrap. drop_cnt saturates the same way.
- flush:
  - In the cycle flush=1, readies are forced 0 and no grant occurs.
  - we=0 next cycle.
  - last_grant and the counters are unchanged; stall_cnt does not count that cycle.
- Reset mid-operation: an in-flight output write is lost (we drops immediately and asynchronously). Requesters must re-present after reset.

Test Plan:
- Reset with a_valid=b_valid=1 held, then release rst → first cycle a_ready=1, b_ready=0; next cycle we=1, wAddr=a_addr, wData=a_data.
- A (addr 5, 0xDEADBEEF) and B (addr 7, 0x12345678) both valid and held 4 cycles → grants alternate A,B,A,B; we high 4 consecutive cycles with addrs 5,7,5,7; stall_cnt=4.
- Only B valid, addr 0, data 0xFFFFFFFF, ZERO_REG_EN=1 → b_ready=1, we stays 0, drop_cnt=1; repeat with ZERO_REG_EN=0 → we=1, wAddr=0.
- Grant A in cycle N and assert flush in N+1 with both valid → no ready in N+1; the A write from N still appears in N+1; N+2 has we=0; N+2 grant goes to B.
- Preload stall_cnt to near saturation via 65540 cycles of dual valid (CNT_W=16) → stall_cnt holds 0xFFFF, no wrap.
- Assert rst low asynchronously mid-cycle while we=1 → we, wAddr, wData, counters read 0 before the next clock edge.

Source files
------------

// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: round-robin share of the register-file write port between ALU (A) and load (B) writeback
module rf_wr_arbiter #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int ZERO_REG_EN = 1,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              we,
  output logic [ADDR_W-1:0] wAddr,
  output logic [DATA_W-1:0] wData,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);
  logic              last_b;
  logic              gnt_a, gnt_b, gnt, drop, stall;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_data;
  always_comb begin
    gnt_a  = !flush && a_valid && (!b_valid || last_b);
    gnt_b  = !flush && b_valid && (!a_valid || !last_b);
    gnt    = gnt_a || gnt_b;
    g_addr = gnt_a ? a_addr : b_addr;
    g_data = gnt_a ? a_data : b_data;
    drop   = gnt && (ZERO_REG_EN != 0) && (g_addr == '0);
    stall  = !flush && a_valid && b_valid;
  end
  assign a_ready = gnt_a;
  assign b_ready = gnt_b;
  // last_b resets high so A wins the first tie
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we        <= 1'b0;
      wAddr     <= '0;
      wData     <= '0;
      stall_cnt <= '0;
      drop_cnt  <= '0;
      last_b    <= 1'b1;
    end else begin
      we <= gnt && !drop;
      if (gnt) begin
        wAddr  <= g_addr;
        wData  <= g_data;
        last_b <= gnt_b;
      end
      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (drop && !(&drop_cnt)) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// tb_rf_wr_arbiter: vector table plus scoreboard of expected register-file writes
module tb_rf_wr_arbiter;
  logic        clk = 1'b0;
  logic        rst, flush;
  logic        a_valid, b_valid, a_ready, b_ready, we;
  logic [4:0]  a_addr, b_addr, wAddr;
  logic [31:0] a_data, b_data, wData;
  logic [15:0] stall_cnt, drop_cnt;
  logic        z_av, z_bv, z_ar, z_br, z_we;
  logic [4:0]  z_aa, z_ba, z_wa;
  logic [31:0] z_ad, z_bd, z_wd;
  logic [3:0]  z_stall, z_drop;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rf_wr_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .we(we), .wAddr(wAddr), .wData(wData), .stall_cnt(stall_cnt), .drop_cnt(drop_cnt)
  );

  rf_wr_arbiter #(.ZERO_REG_EN(0), .CNT_W(4)) dut_z (
    .clk(clk), .rst(rst), .flush(1'b0),
    .a_valid(z_av), .a_ready(z_ar), .a_addr(z_aa), .a_data(z_ad),
    .b_valid(z_bv), .b_ready(z_br), .b_addr(z_ba), .b_data(z_bd),
    .we(z_we), .wAddr(z_wa), .wData(z_wd), .stall_cnt(z_stall), .drop_cnt(z_drop)
  );

  typedef struct {
    logic av; logic [4:0] aa; logic [31:0] ad;
    logic bv; logic [4:0] ba; logic [31:0] bd;
    logic fl;
    logic ear, ebr;
    logic ewe; logic [4:0] ea; logic [31:0] edt;
    logic [15:0] es, ed;
  } vec_t;

  typedef struct { logic we; logic [4:0] a; logic [31:0] d; } wr_t;
  wr_t sb[$];
  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out();
    wr_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("we", {31'd0, we}, {31'd0, e.we});
      if (e.we) begin
        chk("wAddr", {27'd0, wAddr}, {27'd0, e.a});
        chk("wData", wData, e.d);
      end
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    check_out();
    chk($sformatf("stall_cnt[%0d]", idx), {16'd0, stall_cnt}, {16'd0, v.es});
    chk($sformatf("drop_cnt[%0d]", idx), {16'd0, drop_cnt}, {16'd0, v.ed});
    a_valid = v.av; a_addr = v.aa; a_data = v.ad;
    b_valid = v.bv; b_addr = v.ba; b_data = v.bd;
    flush = v.fl;
    #1;
    chk($sformatf("a_ready[%0d]", idx), {31'd0, a_ready}, {31'd0, v.ear});
    chk($sformatf("b_ready[%0d]", idx), {31'd0, b_ready}, {31'd0, v.ebr});
    sb.push_back('{we: v.ewe, a: v.ea, d: v.edt});
  endtask

  initial begin
    //        av aa  ad            bv ba  bd            fl ear ebr ewe ea  edt           es ed
    tbl[0]  = '{1, 5, 32'hDEADBEEF, 1, 7, 32'h12345678, 0, 0, 1, 1, 7,  32'h12345678, 1, 0};
    tbl[1]  = '{1, 5, 32'hDEADBEEF, 1, 7, 32'h12345678, 0, 1, 0, 1, 5,  32'hDEADBEEF, 2, 0};
    tbl[2]  = '{1, 5, 32'hDEADBEEF, 1, 7, 32'h12345678, 0, 0, 1, 1, 7,  32'h12345678, 3, 0};
    tbl[3]  = '{0, 0, 32'h0,        1, 0, 32'hFFFFFFFF, 0, 0, 1, 0, 0,  32'h0,        4, 0};
    tbl[4]  = '{1, 9, 32'h1,        0, 0, 32'h0,        0, 1, 0, 1, 9,  32'h1,        4, 1};
    tbl[5]  = '{0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 0,  32'h0,        4, 1};
    tbl[6]  = '{1, 4, 32'hAA,       1, 4, 32'hBB,       0, 0, 1, 1, 4,  32'hBB,       4, 1};
    tbl[7]  = '{1, 4, 32'hAA,       1, 4, 32'hBB,       0, 1, 0, 1, 4,  32'hAA,       5, 1};
    tbl[8]  = '{1, 10, 32'h10,      0, 0, 32'h0,        0, 1, 0, 1, 10, 32'h10,       6, 1};
    tbl[9]  = '{1, 5, 32'hDEADBEEF, 1, 7, 32'h12345678, 1, 0, 0, 0, 0,  32'h0,        6, 1};
    tbl[10] = '{1, 5, 32'hDEADBEEF, 1, 7, 32'h12345678, 0, 0, 1, 1, 7,  32'h12345678, 6, 1};
    tbl[11] = '{0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 0,  32'h0,        7, 1};
    tbl[12] = '{0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 0,  32'h0,        7, 1};
    rst = 1'b0; flush = 1'b0;
    a_valid = 0; a_addr = 0; a_data = 0; b_valid = 0; b_addr = 0; b_data = 0;
    z_av = 0; z_aa = 0; z_ad = 0; z_bv = 0; z_ba = 0; z_bd = 0;
    repeat (2) @(negedge clk);
    chk("rst we", {31'd0, we}, 32'd0);
    chk("rst wAddr", {27'd0, wAddr}, 32'd0);
    chk("rst wData", wData, 32'd0);
    chk("rst stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("rst drop_cnt", {16'd0, drop_cnt}, 32'd0);
    @(negedge clk);
    a_valid = 1; a_addr = 5; a_data = 32'hDEADBEEF;
    b_valid = 1; b_addr = 7; b_data = 32'h12345678;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("first a_ready", {31'd0, a_ready}, 32'd1);
    chk("first b_ready", {31'd0, b_ready}, 32'd0);
    sb.push_back('{we: 1'b1, a: 5'd5, d: 32'hDEADBEEF});
    for (int i = 0; i < 13; i++) apply(tbl[i], i);
    while (sb.size() > 0) begin
      @(negedge clk);
      check_out();
    end
    // address 0 is a real write when the zero-register discard is disabled
    @(negedge clk);
    z_bv = 1; z_ba = 0; z_bd = 32'hFFFFFFFF;
    #1;
    chk("z b_ready", {31'd0, z_br}, 32'd1);
    chk("z a_ready", {31'd0, z_ar}, 32'd0);
    @(negedge clk);
    z_bv = 0;
    chk("z we", {31'd0, z_we}, 32'd1);
    chk("z wAddr", {27'd0, z_wa}, 32'd0);
    chk("z wData", z_wd, 32'hFFFFFFFF);
    chk("z drop_cnt", {28'd0, z_drop}, 32'd0);
    z_av = 1; z_aa = 1; z_ad = 32'h1; z_bv = 1; z_ba = 2; z_bd = 32'h2;
    repeat (20) @(negedge clk);
    z_av = 0; z_bv = 0;
    @(negedge clk);
    chk("z stall_cnt saturate", {28'd0, z_stall}, 32'd15);
    // async reset while a write is on the port
    @(negedge clk);
    a_valid = 1; a_addr = 3; a_data = 32'h33; b_valid = 0;
    @(posedge clk);
    #2;
    a_valid = 0;
    chk("pre-reset we", {31'd0, we}, 32'd1);
    rst = 1'b0;
    #1;
    chk("async we", {31'd0, we}, 32'd0);
    chk("async wAddr", {27'd0, wAddr}, 32'd0);
    chk("async wData", wData, 32'd0);
    chk("async stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("async drop_cnt", {16'd0, drop_cnt}, 32'd0);
    chk("async z_stall", {28'd0, z_stall}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
